tune_pio_ext: RTL and testbench
===============================

Name: tune_pio_ext

Overview:
- Parametrised Avalon-MM slave output PIO for the tuning/control path.
- Generalises the single 32-bit output register to a configurable data width.
- Adds per-bit set/clear registers, a double-buffered shadow register with commit/apply, and an optional auto-revert pulse timer.
- Sits on the CPU Avalon bus and drives tuner/front-end control lines through out_port.

Parameters:
- DATA_WIDTH, 32, width of out_port and of the data registers (1..32)
- RESET_VALUE, 0, value of the live and shadow registers after reset
- PULSE_W, 16, width of the pulse-timer counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- chipselect  in  1  slave select
- address  in  3  register word address
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- out_port  out  DATA_WIDTH  live output register
- readdata  out  32  combinational read mux, zero-extended
- busy  out  1  high while the pulse timer is running

Behaviour:
- Write strobe: wr = chipselect & ~write_n. All register updates occur on the rising edge of clk.
- Reset (reset_n=0 at a clock edge):
  - live = shadow = RESET_VALUE
  - pulse_mask = 0, pulse_len = 0, cnt = 0, busy = 0, pending = 0
  - Reset overrides any same-cycle write.
  - A reset asserted mid-pulse aborts the pulse; out_port returns to RESET_VALUE on that edge.
- Register map (only writedata[DATA_WIDTH-1:0] is used; other bits ignored on write and read as 0):
  - 0 DATA: write sets live directly; takes effect on out_port on the next edge. Read returns live.
  - 1 SET: live <= live | wd. Read returns 0.
  - 2 CLEAR: live <= live & ~wd. Read returns 0.
  - 3 SHADOW: write sets shadow and pending = 1. Read returns shadow.
  - 4 COMMIT: write with wd[0]=1 gives live <= shadow and pending = 0; wd[0]=0 has no effect. Read returns {30'b0, busy, pending}.
  - 5 PULSE_MASK: bits of live inverted during a pulse. Read/write.
  - 6 PULSE_LEN: low PULSE_W bits = pulse length in cycles. Read/write.
  - 7 PULSE_GO: write with wd[0]=1 starts a pulse. Read returns cnt zero-extended.
- Pulse state machine: IDLE / ACTIVE.
  - IDLE -> ACTIVE on GO, only when pulse_len != 0 and busy = 0.
  - On entry: live <= live ^ pulse_mask, cnt <= pulse_len, busy = 1.
  - While ACTIVE: cnt decrements each cycle.
  - At cnt == 1: next edge gives live <= live ^ pulse_mask, cnt = 0, busy = 0, return to IDLE.
  - Net effect: out_port is inverted for exactly pulse_len cycles.
  - GO while busy is ignored. GO with pulse_len = 0 is ignored.
  - DATA/SET/CLEAR/COMMIT while ACTIVE update live normally; the end-of-pulse XOR is applied to the updated value.
  - A write to PULSE_MASK during ACTIVE takes effect only at the next GO; the latched mask is held for the whole pulse.
- Collisions: only one bus write per cycle. A bus write in the same cycle as the end-of-pulse toggle gives live <= f(write) ^ latched_mask.
- readdata: combinational, zero latency; 0 when chipselect = 0.
- Unused address decodes read as 0.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with RESET_VALUE=32'hA5 -> out_port=0xA5, readdata@0=0xA5, busy=0. A write asserted during reset is ignored.
- Set/clear: DATA=0x0F0F, SET=0xF000, CLEAR=0x000F -> out_port=0xFF00 one cycle after each write.
- Shadow: SHADOW=0x1234 -> out_port unchanged, status=0x1. COMMIT wd=1 -> out_port=0x1234, status=0x0. COMMIT wd=0 -> no change.
- Pulse: live=0x0, MASK=0x3, LEN=4, GO -> out_port=0x3 for exactly 4 cycles then 0x0. busy is high for the same 4 cycles. A second GO mid-pulse is ignored.
- Boundaries: LEN=0 with GO -> no change, busy=0. SET=0x4 on the final pulse cycle -> out_port=0x4 after the pulse. Reset asserted during a pulse -> immediate RESET_VALUE, busy=0.
- Width: DATA_WIDTH=8, write 0xFFFF_FFFF to DATA -> out_port=0xFF, readdata=0x0000_00FF.

Source files
------------

// File: rtl/tune_pio_ext.sv
// tune_pio_ext: parametrised Avalon-MM output PIO for the tuner/front-end
// control lines. Live register with direct/set/clear access, a
// double-buffered shadow register committed on demand, and a pulse timer
// that inverts selected output bits for a programmable number of cycles.
module tune_pio_ext #(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int          PULSE_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  chipselect,
   input  logic [2:0]            address,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [31:0]           readdata,
   output logic                  busy
);

   localparam logic [2:0] A_DATA    = 3'd0;
   localparam logic [2:0] A_SET     = 3'd1;
   localparam logic [2:0] A_CLEAR   = 3'd2;
   localparam logic [2:0] A_SHADOW  = 3'd3;
   localparam logic [2:0] A_COMMIT  = 3'd4;
   localparam logic [2:0] A_MASK    = 3'd5;
   localparam logic [2:0] A_LEN     = 3'd6;
   localparam logic [2:0] A_GO      = 3'd7;

   localparam logic [DATA_WIDTH-1:0] RST_VAL = RESET_VALUE[DATA_WIDTH-1:0];
   localparam logic [PULSE_W-1:0]    CNT_ONE = PULSE_W'(1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   live, live_nxt, live_upd;
   logic [DATA_WIDTH-1:0]   shadow, shadow_nxt;
   logic [DATA_WIDTH-1:0]   pulse_mask, pulse_mask_nxt;
   logic [DATA_WIDTH-1:0]   latched_mask, latched_mask_nxt;
   logic [PULSE_W-1:0]      pulse_len, pulse_len_nxt;
   logic [PULSE_W-1:0]      cnt, cnt_nxt;
   logic                    pending, pending_nxt;
   logic                    wr;
   logic                    go;
   logic [DATA_WIDTH-1:0]   wd;

   // Upper writedata bits beyond DATA_WIDTH are intentionally ignored.
   logic unused_wd;
   assign unused_wd = ^writedata;

   assign wr       = chipselect & ~write_n;
   assign wd       = writedata[DATA_WIDTH-1:0];
   assign go       = wr && (address == A_GO) && writedata[0];
   assign busy     = (state == ACTIVE);
   assign out_port = live;

   // State register: all control state, synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      if (!reset_n) begin
         state        <= IDLE;
         live         <= RST_VAL;
         shadow       <= RST_VAL;
         pulse_mask   <= '0;
         latched_mask <= '0;
         pulse_len    <= '0;
         cnt          <= '0;
         pending      <= 1'b0;
      end else begin
         state        <= state_nxt;
         live         <= live_nxt;
         shadow       <= shadow_nxt;
         pulse_mask   <= pulse_mask_nxt;
         latched_mask <= latched_mask_nxt;
         pulse_len    <= pulse_len_nxt;
         cnt          <= cnt_nxt;
         pending      <= pending_nxt;
      end
   end

   // Bus-write decode, then pulse FSM applying its XOR on top of the
   // bus-updated live value.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      live_upd         = live;
      shadow_nxt       = shadow;
      pulse_mask_nxt   = pulse_mask;
      pulse_len_nxt    = pulse_len;
      pending_nxt      = pending;
      state_nxt        = state;
      cnt_nxt          = cnt;
      latched_mask_nxt = latched_mask;

      if (wr) begin
         case (address)
            A_DATA:   live_upd = wd;
            A_SET:    live_upd = live | wd;
            A_CLEAR:  live_upd = live & ~wd;
            A_SHADOW: begin
               shadow_nxt  = wd;
               pending_nxt = 1'b1;
            end
            A_COMMIT: begin
               if (writedata[0]) begin
                  live_upd    = shadow;
                  pending_nxt = 1'b0;
               end
            end
            A_MASK:   pulse_mask_nxt = wd;
            A_LEN:    pulse_len_nxt  = writedata[PULSE_W-1:0];
            default:  ;
         endcase
      end

      live_nxt = live_upd;

      case (state)
         IDLE: begin
            if (go && (pulse_len != '0)) begin
               state_nxt        = ACTIVE;
               live_nxt         = live_upd ^ pulse_mask;
               cnt_nxt          = pulse_len;
               latched_mask_nxt = pulse_mask;
            end
         end
         ACTIVE: begin
            // GO during a pulse is ignored; the latched mask holds.
            if (cnt == CNT_ONE) begin
               state_nxt = IDLE;
               live_nxt  = live_upd ^ latched_mask;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Zero-latency read mux, zero-extended, 0 when not selected.
   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            A_DATA:   readdata[DATA_WIDTH-1:0] = live;
            A_SHADOW: readdata[DATA_WIDTH-1:0] = shadow;
            A_COMMIT: readdata[1:0]            = {busy, pending};
            A_MASK:   readdata[DATA_WIDTH-1:0] = pulse_mask;
            A_LEN:    readdata[PULSE_W-1:0]    = pulse_len;
            A_GO:     readdata[PULSE_W-1:0]    = cnt;
            default:  readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_tune_pio_ext.sv
// tb_tune_pio_ext: directed tests for tune_pio_ext with hand-computed
// expected values; a second 8-bit instance covers the width truncation.
module tb_tune_pio_ext;

   logic        clk;
   logic        reset_n;
   logic        chipselect;
   logic        cs8;
   logic [2:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] out_port;
   logic [31:0] readdata;
   logic        busy;
   logic [7:0]  out8;
   logic [31:0] readdata8;
   logic        busy8;

   int total = 0;
   int bad   = 0;

   tune_pio_ext #(
      .DATA_WIDTH (32),
      .RESET_VALUE(32'hA5),
      .PULSE_W    (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .chipselect(chipselect),
      .address   (address),
      .write_n   (write_n),
      .writedata (writedata),
      .out_port  (out_port),
      .readdata  (readdata),
      .busy      (busy)
   );

   tune_pio_ext #(
      .DATA_WIDTH(8)
   ) dut8 (
      .clk       (clk),
      .reset_n   (reset_n),
      .chipselect(cs8),
      .address   (address),
      .write_n   (write_n),
      .writedata (writedata),
      .out_port  (out8),
      .readdata  (readdata8),
      .busy      (busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle write to the 32-bit instance.
   task automatic wr32(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // One-cycle write to the 8-bit instance.
   task automatic wr8(input logic [2:0] a, input logic [31:0] d);
      cs8       = 1'b1;
      write_n   = 1'b0;
      address   = a;
      writedata = d;
      tick();
      cs8       = 1'b0;
      write_n   = 1'b1;
   endtask

   // Combinational read of the 32-bit instance (no clock edge consumed).
   task automatic rd32(input logic [2:0] a, output logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      #1;
      d          = readdata;
      chipselect = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      reset_n    = 1'b0;
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = 3'd0;
      writedata  = 32'h5555_5555;
      tick();
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      total++;
      if (out_port !== 32'hA5) begin
         bad++;
         $display("FAIL reset_out got=%h exp=%h", out_port, 32'hA5);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      total++;
      if (out8 !== 8'h00) begin
         bad++;
         $display("FAIL reset_out8 got=%h exp=00", out8);
      end
      reset_n = 1'b1;
      tick();
      rd32(3'd0, r);
      total++;
      if (r !== 32'hA5) begin
         bad++;
         $display("FAIL reset_read_data got=%h exp=%h", r, 32'hA5);
      end
      rd32(3'd4, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL reset_status got=%h exp=0", r);
      end
   endtask

   task automatic test_set_clear();
      logic [31:0] r;
      wr32(3'd0, 32'h0F0F);
      total++;
      if (out_port !== 32'h0F0F) begin
         bad++;
         $display("FAIL data_write got=%h exp=%h", out_port, 32'h0F0F);
      end
      wr32(3'd1, 32'hF000);
      total++;
      if (out_port !== 32'hFF0F) begin
         bad++;
         $display("FAIL set got=%h exp=%h", out_port, 32'hFF0F);
      end
      wr32(3'd2, 32'h000F);
      total++;
      if (out_port !== 32'hFF00) begin
         bad++;
         $display("FAIL clear got=%h exp=%h", out_port, 32'hFF00);
      end
      rd32(3'd0, r);
      total++;
      if (r !== 32'hFF00) begin
         bad++;
         $display("FAIL read_live got=%h exp=%h", r, 32'hFF00);
      end
      rd32(3'd1, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL read_set got=%h exp=0", r);
      end
      // Unselected read returns zero.
      address = 3'd0;
      #1;
      total++;
      if (readdata !== 32'h0) begin
         bad++;
         $display("FAIL read_nocs got=%h exp=0", readdata);
      end
   endtask

   task automatic test_shadow();
      logic [31:0] r;
      wr32(3'd3, 32'h1234);
      total++;
      if (out_port !== 32'hFF00) begin
         bad++;
         $display("FAIL shadow_no_effect got=%h exp=%h", out_port, 32'hFF00);
      end
      rd32(3'd4, r);
      total++;
      if (r !== 32'h1) begin
         bad++;
         $display("FAIL shadow_pending got=%h exp=1", r);
      end
      rd32(3'd3, r);
      total++;
      if (r !== 32'h1234) begin
         bad++;
         $display("FAIL shadow_read got=%h exp=%h", r, 32'h1234);
      end
      wr32(3'd4, 32'h1);
      total++;
      if (out_port !== 32'h1234) begin
         bad++;
         $display("FAIL commit got=%h exp=%h", out_port, 32'h1234);
      end
      rd32(3'd4, r);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL commit_status got=%h exp=0", r);
      end
      wr32(3'd3, 32'h5678);
      wr32(3'd4, 32'h0);
      total++;
      if (out_port !== 32'h1234) begin
         bad++;
         $display("FAIL commit0 got=%h exp=%h", out_port, 32'h1234);
      end
      rd32(3'd4, r);
      total++;
      if (r !== 32'h1) begin
         bad++;
         $display("FAIL commit0_status got=%h exp=1", r);
      end
   endtask

   task automatic test_pulse();
      logic [31:0] r;
      wr32(3'd0, 32'h0);
      wr32(3'd5, 32'h3);
      wr32(3'd6, 32'h4);
      wr32(3'd7, 32'h1);
      // Pulse cycle 1.
      total++;
      if (out_port !== 32'h3 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pulse_c1 got=%h/%b exp=3/1", out_port, busy);
      end
      // Second GO mid-pulse must be ignored (pulse cycle 2).
      wr32(3'd7, 32'h1);
      total++;
      if (out_port !== 32'h3 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pulse_c2 got=%h/%b exp=3/1", out_port, busy);
      end
      rd32(3'd7, r);
      total++;
      if (r !== 32'd3) begin
         bad++;
         $display("FAIL pulse_cnt got=%0d exp=3", r);
      end
      for (int i = 3; i <= 4; i++) begin
         tick();
         total++;
         if (out_port !== 32'h3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pulse_c%0d got=%h/%b exp=3/1", i, out_port, busy);
         end
      end
      tick();
      total++;
      if (out_port !== 32'h0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL pulse_end got=%h/%b exp=0/0", out_port, busy);
      end
      tick();
      total++;
      if (out_port !== 32'h0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL pulse_no_restart got=%h/%b exp=0/0", out_port, busy);
      end
   endtask

   task automatic test_boundaries();
      // Length zero: GO ignored.
      wr32(3'd6, 32'h0);
      wr32(3'd7, 32'h1);
      total++;
      if (out_port !== 32'h0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL len0_go got=%h/%b exp=0/0", out_port, busy);
      end
      // SET on the final pulse cycle: (0^3 | 4) ^ 3 = 4.
      wr32(3'd6, 32'h2);
      wr32(3'd7, 32'h1);
      tick();
      wr32(3'd1, 32'h4);
      total++;
      if (out_port !== 32'h4 || busy !== 1'b0) begin
         bad++;
         $display("FAIL set_at_end got=%h/%b exp=4/0", out_port, busy);
      end
      // Mask write during a pulse does not affect the restore.
      wr32(3'd6, 32'h3);
      wr32(3'd7, 32'h1);
      wr32(3'd5, 32'hF0);
      tick();
      tick();
      total++;
      if (out_port !== 32'h4 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mask_latched got=%h/%b exp=4/0", out_port, busy);
      end
      // Reset mid-pulse aborts to RESET_VALUE.
      wr32(3'd7, 32'h1);
      total++;
      if (out_port !== 32'hF4 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pulse_new_mask got=%h/%b exp=f4/1", out_port, busy);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      total++;
      if (out_port !== 32'hA5 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_pulse got=%h/%b exp=a5/0", out_port, busy);
      end
   endtask

   task automatic test_width();
      wr8(3'd0, 32'hFFFF_FFFF);
      total++;
      if (out8 !== 8'hFF) begin
         bad++;
         $display("FAIL width_out got=%h exp=ff", out8);
      end
      cs8     = 1'b1;
      address = 3'd0;
      #1;
      total++;
      if (readdata8 !== 32'h0000_00FF) begin
         bad++;
         $display("FAIL width_read got=%h exp=%h", readdata8, 32'hFF);
      end
      cs8 = 1'b0;
      total++;
      if (out_port !== 32'hA5) begin
         bad++;
         $display("FAIL width_isolation got=%h exp=a5", out_port);
      end
   endtask

   initial begin
      chipselect = 1'b0;
      cs8        = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 32'h0;
      reset_n    = 1'b0;
      test_reset();
      test_set_clear();
      test_shadow();
      test_pulse();
      test_boundaries();
      test_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
